// File: rtl/mult_result_buf.sv
// mult_result_buf: result landing buffer behind the non-stallable 64b multiplier.
// Results are held in a FIFO with a first-word-fall-through output register.
// A credit counter (in-flight + buffered) gates upstream issue so that no
// result is ever dropped when the upstream honours o_issueRdy.
module mult_result_buf #(
    parameter int DEPTH = 32,
    parameter int DW    = 64,
    parameter int IDW   = 9
) (
    input  logic                       ck,
    input  logic                       rst_n,
    input  logic                       i_issue,
    output logic                       o_issueRdy,
    input  logic                       i_vld,
    input  logic [DW-1:0]              i_res,
    input  logic [IDW-1:0]             i_htId,
    output logic                       o_vld,
    output logic [DW-1:0]              o_res,
    output logic [IDW-1:0]             o_htId,
    input  logic                       i_rdy,
    output logic [$clog2(DEPTH):0]     o_cnt,
    output logic                       o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DW + IDW;

    // Storage behind the output register. The output register itself counts
    // as one entry, so at most DEPTH-1 words ever sit here.
    logic [EW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0] occ_q,      occ_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          out_vld_q,  out_vld_d;
    logic [DW-1:0] out_res_q,  out_res_d;
    logic [IDW-1:0] out_id_q,  out_id_d;
    logic          issue_rdy_q, issue_rdy_d;
    logic          err_q,      err_d;

    logic          pop;
    logic          push;
    logic          full;
    logic          mem_empty;
    logic          load_out;
    logic          from_mem;
    logic          bypass;
    logic          mem_we;
    logic          infl_dec;
    logic [CW-1:0] mem_cnt;
    logic [CW:0]   credit_sum;
    logic [EW-1:0] mem_head;

    assign mem_head = mem_q[rd_ptr_q];

    // Handshake decode: who pushes, who pops, and where the output register
    // gets its next word (storage head first, otherwise the arriving result).
    always_comb begin
        pop       = out_vld_q & i_rdy;
        full      = (occ_q == CW'(DEPTH));
        push      = i_vld & (~full | pop);
        mem_cnt   = occ_q - CW'(out_vld_q);
        mem_empty = (mem_cnt == '0);
        load_out  = ~out_vld_q | pop;
        from_mem  = load_out & ~mem_empty;
        bypass    = load_out & mem_empty & push;
        mem_we    = push & ~bypass;
        infl_dec  = i_vld & (inflight_q != '0);
    end

    // Next-state for pointers, counters, output register, credit and error.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        inflight_d  = inflight_q;
        out_vld_d   = out_vld_q;
        out_res_d   = out_res_q;
        out_id_d    = out_id_q;
        issue_rdy_d = issue_rdy_q;
        err_d       = err_q;
        credit_sum  = '0;

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (from_mem) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        occ_d      = occ_q + CW'(push) - CW'(pop);
        // A result with nothing in flight still lands, but never underflows
        // the in-flight count.
        inflight_d = inflight_q + CW'(i_issue) - CW'(infl_dec);

        if (from_mem) begin
            out_vld_d = 1'b1;
            out_res_d = mem_head[EW-1:IDW];
            out_id_d  = mem_head[IDW-1:0];
        end else if (bypass) begin
            out_vld_d = 1'b1;
            out_res_d = i_res;
            out_id_d  = i_htId;
        end else if (load_out) begin
            out_vld_d = 1'b0;
        end

        credit_sum  = {1'b0, inflight_d} + {1'b0, occ_d};
        issue_rdy_d = (credit_sum < (CW+1)'(DEPTH));

        if ((i_issue & ~issue_rdy_q) | (i_vld & (inflight_q == '0)) | (i_vld & ~push)) begin
            err_d = 1'b1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            inflight_q  <= '0;
            out_vld_q   <= 1'b0;
            out_res_q   <= '0;
            out_id_q    <= '0;
            issue_rdy_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            out_vld_q   <= out_vld_d;
            out_res_q   <= out_res_d;
            out_id_q    <= out_id_d;
            issue_rdy_q <= issue_rdy_d;
            err_q       <= err_d;
        end
    end

    // Storage write port; contents need no reset since pointers gate reads.
    always_ff @(posedge ck) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {i_res, i_htId};
        end
    end

    assign o_vld      = out_vld_q;
    assign o_res      = out_res_q;
    assign o_htId     = out_id_q;
    assign o_cnt      = occ_q;
    assign o_err      = err_q;
    assign o_issueRdy = issue_rdy_q;

endmodule
